// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that sequences an i2cmb core through bus init, address,
// data and stop phases for byte-stream I2C read/write requests.
module i2cmb_wb_sequencer #(
  parameter int unsigned WB_ADDR_WIDTH = 2,
  parameter int unsigned WB_DATA_WIDTH = 8,
  parameter int unsigned BUS_ID        = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_rw_i,
  input  logic [6:0]               req_addr_i,
  input  logic [3:0]               req_len_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     wr_data_valid_i,
  output logic                     wr_data_ready_o,
  output logic [7:0]               rd_data_o,
  output logic                     rd_data_valid_o,
  output logic                     done_o,
  output logic                     nack_o,
  output logic                     err_o,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     irq_i
);

  typedef enum logic [4:0] {
    StInitCsr, StInitDpr, StInitCmd, StInitWait, StIdle, StStart, StStartWait,
    StAddrDpr, StAddrCmd, StAddrWait, StWrGet, StWrDpr, StWrCmd, StWrWait,
    StRdCmd, StRdWait, StRdDpr, StStopCmd, StStopWait, StDone
  } state_e;

  localparam logic [1:0] RegCsr  = 2'd0;
  localparam logic [1:0] RegDpr  = 2'd1;
  localparam logic [1:0] RegCmdr = 2'd2;

  localparam logic [7:0] CmdStart  = 8'h04;
  localparam logic [7:0] CmdStop   = 8'h05;
  localparam logic [7:0] CmdWrite  = 8'h01;
  localparam logic [7:0] CmdRdAck  = 8'h02;
  localparam logic [7:0] CmdRdNak  = 8'h03;
  localparam logic [7:0] CmdSetBus = 8'h06;

  state_e                   r_state, w_state;
  logic                     r_busy, w_busy;
  logic                     r_we, w_we;
  logic [WB_ADDR_WIDTH-1:0] r_adr, w_adr;
  logic [WB_DATA_WIDTH-1:0] r_dat, w_dat;
  logic                     r_rw, w_rw;
  logic [6:0]               r_addr, w_addr;
  logic [4:0]               r_cnt, w_cnt;
  logic [7:0]               r_wbyte, w_wbyte;
  logic                     r_nack, w_nack;
  logic                     r_err, w_err;
  logic [7:0]               r_rd_data, w_rd_data;
  logic                     r_rd_valid, w_rd_valid;

  logic       w_req, w_req_we;
  logic [1:0] w_req_adr;
  logic [7:0] w_req_dat;
  logic       w_ack, w_stat_any, w_nak, w_abort, w_last;

  assign w_ack      = r_busy & ack_i;
  assign w_stat_any = |dat_i[7:4];
  assign w_nak      = dat_i[6];
  assign w_abort    = dat_i[5] | dat_i[4];
  assign w_last     = (r_cnt == 5'd1);

  always_comb begin
    w_state    = r_state;
    w_busy     = r_busy;
    w_we       = r_we;
    w_adr      = r_adr;
    w_dat      = r_dat;
    w_rw       = r_rw;
    w_addr     = r_addr;
    w_cnt      = r_cnt;
    w_wbyte    = r_wbyte;
    w_nack     = r_nack;
    w_err      = r_err;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    w_req      = 1'b0;
    w_req_we   = 1'b0;
    w_req_adr  = RegCmdr;
    w_req_dat  = 8'h00;

    unique case (r_state)
      StInitCsr: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = RegCsr; w_req_dat = 8'hC0;
        if (w_ack) w_state = StInitDpr;
      end
      StInitDpr: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = RegDpr; w_req_dat = 8'(BUS_ID);
        if (w_ack) w_state = StInitCmd;
      end
      StInitCmd: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = CmdSetBus;
        if (w_ack) w_state = StInitWait;
      end
      StInitWait: begin
        w_req = irq_i;
        if (w_ack && w_stat_any) w_state = StIdle;
      end
      StIdle: begin
        if (req_valid_i) begin
          w_rw    = req_rw_i;
          w_addr  = req_addr_i;
          w_cnt   = (req_len_i == 4'd0) ? 5'd16 : {1'b0, req_len_i};
          w_nack  = 1'b0;
          w_err   = 1'b0;
          w_state = StStart;
        end
      end
      StStart: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = CmdStart;
        if (w_ack) w_state = StStartWait;
      end
      StStartWait: begin
        w_req = irq_i;
        if (w_ack && w_stat_any) begin
          w_err   = w_abort;
          w_state = w_abort ? StDone : StAddrDpr;
        end
      end
      StAddrDpr: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = RegDpr; w_req_dat = {r_addr, r_rw};
        if (w_ack) w_state = StAddrCmd;
      end
      StAddrCmd: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = CmdWrite;
        if (w_ack) w_state = StAddrWait;
      end
      StAddrWait: begin
        w_req = irq_i;
        if (w_ack && w_stat_any) begin
          if (w_abort) begin
            w_err = 1'b1; w_state = StDone;
          end else if (w_nak) begin
            w_nack = 1'b1; w_state = StStopCmd;
          end else begin
            w_state = r_rw ? StRdCmd : StWrGet;
          end
        end
      end
      StWrGet: begin
        if (wr_data_valid_i) begin
          w_wbyte = wr_data_i;
          w_state = StWrDpr;
        end
      end
      StWrDpr: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_adr = RegDpr; w_req_dat = r_wbyte;
        if (w_ack) w_state = StWrCmd;
      end
      StWrCmd: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = CmdWrite;
        if (w_ack) w_state = StWrWait;
      end
      StWrWait: begin
        w_req = irq_i;
        if (w_ack && w_stat_any) begin
          if (w_abort) begin
            w_err = 1'b1; w_state = StDone;
          end else if (w_nak) begin
            w_nack = 1'b1; w_state = StStopCmd;
          end else begin
            w_cnt   = r_cnt - 5'd1;
            w_state = w_last ? StStopCmd : StWrGet;
          end
        end
      end
      StRdCmd: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = w_last ? CmdRdNak : CmdRdAck;
        if (w_ack) w_state = StRdWait;
      end
      StRdWait: begin
        w_req = irq_i;
        if (w_ack && w_stat_any) begin
          w_err   = w_abort;
          w_state = w_abort ? StDone : StRdDpr;
        end
      end
      StRdDpr: begin
        w_req = 1'b1; w_req_adr = RegDpr;
        if (w_ack) begin
          w_rd_valid = 1'b1;
          w_rd_data  = dat_i[7:0];
          w_cnt      = r_cnt - 5'd1;
          w_state    = w_last ? StStopCmd : StRdCmd;
        end
      end
      StStopCmd: begin
        w_req = 1'b1; w_req_we = 1'b1; w_req_dat = CmdStop;
        if (w_ack) w_state = StStopWait;
      end
      StStopWait: begin
        w_req = irq_i;
        if (w_ack && w_stat_any) begin
          if (w_abort) w_err = 1'b1;
          w_state = StDone;
        end
      end
      StDone:  w_state = StIdle;
      default: w_state = StInitCsr;
    endcase

    // Cycle launches one clock after state entry; ack closes it and forces an idle clock.
    if (w_ack) begin
      w_busy = 1'b0;
      w_we   = 1'b0;
      w_adr  = '0;
      w_dat  = '0;
    end else if (!r_busy && w_req) begin
      w_busy = 1'b1;
      w_we   = w_req_we;
      w_adr  = WB_ADDR_WIDTH'(w_req_adr);
      w_dat  = WB_DATA_WIDTH'(w_req_dat);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StInitCsr;
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_rw       <= 1'b0;
      r_addr     <= 7'd0;
      r_cnt      <= 5'd0;
      r_wbyte    <= 8'd0;
      r_nack     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_data  <= 8'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_busy     <= w_busy;
      r_we       <= w_we;
      r_adr      <= w_adr;
      r_dat      <= w_dat;
      r_rw       <= w_rw;
      r_addr     <= w_addr;
      r_cnt      <= w_cnt;
      r_wbyte    <= w_wbyte;
      r_nack     <= w_nack;
      r_err      <= w_err;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
    end
  end

  assign req_ready_o     = (r_state == StIdle);
  assign wr_data_ready_o = (r_state == StWrGet);
  assign done_o          = (r_state == StDone);
  assign nack_o          = (r_state == StDone) & r_nack;
  assign err_o           = (r_state == StDone) & r_err;
  assign rd_data_o       = r_rd_data;
  assign rd_data_valid_o = r_rd_valid;
  assign cyc_o           = r_busy;
  assign stb_o           = r_busy;
  assign we_o            = r_we;
  assign adr_o           = r_adr;
  assign dat_o           = r_dat;

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Scoreboard bench: directed requests push expected Wishbone/read/done events,
// an i2cmb slave model answers the bus, and a monitor pops and compares.
module tb_i2cmb_wb_sequencer;

  logic       clk_i, rst_i;
  logic       req_valid_i, req_ready_o, req_rw_i;
  logic [6:0] req_addr_i;
  logic [3:0] req_len_i;
  logic [7:0] wr_data_i;
  logic       wr_data_valid_i, wr_data_ready_o;
  logic [7:0] rd_data_o;
  logic       rd_data_valid_o, done_o, nack_o, err_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic       ack_i;
  logic [7:0] dat_i;
  logic       irq_i;

  i2cmb_wb_sequencer #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .BUS_ID(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i), .wr_data_ready_o(wr_data_ready_o),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
    .done_o(done_o), .nack_o(nack_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i)
  );

  logic [10:0] exp_wb[$];    // {we, adr, dat}; dat ignored for reads
  logic [7:0]  exp_rd[$];
  logic [1:0]  exp_done[$];  // {nack, err}
  logic [7:0]  status_q[$];
  logic [7:0]  rdq[$];
  logic [7:0]  wq[$];

  int vec_cnt = 0, miss_cnt = 0;
  int done_cnt = 0, wr_hs = 0, wr_rdy_cycles = 0;
  int ndone = 0;
  bit stall = 0;
  bit in_cyc = 0;
  logic [10:0] cap;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      miss_cnt++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic void exp_w(input logic [1:0] a, input logic [7:0] d);
    exp_wb.push_back({1'b1, a, d});
  endfunction

  function automatic void exp_r(input logic [1:0] a);
    exp_wb.push_back({1'b0, a, 8'h00});
  endfunction

  function automatic void exp_init();
    exp_w(2'd0, 8'hC0); exp_w(2'd1, 8'h05); exp_w(2'd2, 8'h06); exp_r(2'd2);
  endfunction

  function automatic void exp_hdr(input logic rw);
    exp_w(2'd2, 8'h04); exp_r(2'd2); exp_w(2'd1, {7'h22, rw}); exp_w(2'd2, 8'h01); exp_r(2'd2);
  endfunction

  function automatic void exp_wbyte(input logic [7:0] b);
    exp_w(2'd1, b); exp_w(2'd2, 8'h01); exp_r(2'd2);
  endfunction

  // Slave model: variable ack latency, irq a few clocks after each CMDR write.
  initial begin
    int lat, wcnt, irq_cnt;
    lat = 0; wcnt = 0; irq_cnt = 0;
    ack_i = 0; dat_i = 0; irq_i = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        ack_i = 0; dat_i = 0; irq_i = 0; irq_cnt = 0; wcnt = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) irq_i = 1;
        end
        if (ack_i) begin
          ack_i = 0; dat_i = 0;
        end else if (cyc_o && stb_o && !stall) begin
          if (wcnt < lat) wcnt++;
          else begin
            wcnt = 0; lat = (lat == 0) ? 2 : 0; ack_i = 1;
            if (we_o) begin
              if (adr_o == 2'd2) irq_cnt = 3;
            end else if (adr_o == 2'd2) begin
              dat_i = (status_q.size() > 0) ? status_q.pop_front() : 8'h80;
              irq_i = 0;
            end else if (adr_o == 2'd1) begin
              dat_i = (rdq.size() > 0) ? rdq.pop_front() : 8'hFF;
            end
          end
        end
      end
    end
  end

  // Write byte source: one-cycle valid per byte, only when ready is seen.
  initial begin
    wr_data_valid_i = 0; wr_data_i = 0;
    forever begin
      @(negedge clk_i);
      if (wr_data_valid_i) begin
        if (wq.size() > 0) void'(wq.pop_front());
        wr_hs++;
        wr_data_valid_i = 0;
      end
      if (wr_data_ready_o && !rst_i && wq.size() > 0) begin
        wr_data_valid_i = 1; wr_data_i = wq[0];
      end
    end
  end

  // Monitor.
  initial begin
    logic [10:0] got, e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) in_cyc = 0;
      else begin
        if (cyc_o && stb_o) begin
          got = {we_o, adr_o, dat_o};
          if (!in_cyc) begin
            in_cyc = 1; cap = got;
          end else check("wb_stable", {21'd0, got}, {21'd0, cap});
          if (ack_i) begin
            in_cyc = 0;
            if (exp_wb.size() == 0) begin
              vec_cnt++; miss_cnt++;
              $display("FAIL wb_unexpected: got we=%0b adr=%0d dat=%02h", we_o, adr_o, dat_o);
            end else begin
              e = exp_wb.pop_front();
              if (!e[10]) got[7:0] = 8'h00;
              check("wb_txn", {21'd0, got}, {21'd0, e});
            end
          end
        end
        if (rd_data_valid_o) begin
          if (exp_rd.size() == 0) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL rd_unexpected: got %02h", rd_data_o);
          end else check("rd_data", {24'd0, rd_data_o}, {24'd0, exp_rd.pop_front()});
        end
        if (done_o) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL done_unexpected: nack=%0b err=%0b", nack_o, err_o);
          end else check("done_flags", {30'd0, nack_o, err_o}, {30'd0, exp_done.pop_front()});
        end else check("flags_idle", {30'd0, nack_o, err_o}, 32'd0);
        if (wr_data_ready_o) wr_rdy_cycles++;
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {5'd0, req_ready_o, wr_data_ready_o, rd_data_o, rd_data_valid_o, done_o, nack_o,
            err_o, cyc_o, stb_o, we_o, adr_o, dat_o};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_o && n < 1000) begin @(negedge clk_i); n++; end
    #2 check("req_ready", {31'd0, req_ready_o}, 32'd1);
  endtask

  task automatic send_req(input logic rw, input logic [6:0] a, input logic [3:0] len);
    int n = 0;
    @(negedge clk_i);
    req_valid_i = 1; req_rw_i = rw; req_addr_i = a; req_len_i = len;
    while (!req_ready_o && n < 1000) begin @(negedge clk_i); n++; end
    if (n >= 1000) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL req_accept: ready never seen");
    end
    @(negedge clk_i);
    req_valid_i = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    ndone++;
    while (done_cnt < ndone && n < 4000) begin @(negedge clk_i); n++; end
    check("done_seen", done_cnt, ndone);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int base, rbase, n;
    rst_i = 1; req_valid_i = 0; req_rw_i = 0; req_addr_i = 0; req_len_i = 0;
    repeat (3) @(negedge clk_i);
    #2 check("reset_outputs", all_outs(), 32'd0);

    // Init sequence after reset release.
    exp_init();
    @(negedge clk_i);
    rst_i = 0;
    wait_ready();
    check("init_queue", exp_wb.size(), 0);

    // Three-byte write, all ACK.
    base = wr_hs;
    wq.push_back(8'hDE); wq.push_back(8'hAD); wq.push_back(8'hBE);
    exp_hdr(1'b0);
    exp_wbyte(8'hDE); exp_wbyte(8'hAD); exp_wbyte(8'hBE);
    exp_w(2'd2, 8'h05); exp_r(2'd2);
    exp_done.push_back(2'b00);
    send_req(1'b0, 7'h22, 4'd3);
    wait_done();
    check("wr3_queue", exp_wb.size(), 0);
    check("wr3_handshakes", wr_hs - base, 3);

    // Two-byte read.
    rdq.push_back(8'h0A); rdq.push_back(8'h0B);
    exp_rd.push_back(8'h0A); exp_rd.push_back(8'h0B);
    exp_hdr(1'b1);
    exp_w(2'd2, 8'h02); exp_r(2'd2); exp_r(2'd1);
    exp_w(2'd2, 8'h03); exp_r(2'd2); exp_r(2'd1);
    exp_w(2'd2, 8'h05); exp_r(2'd2);
    exp_done.push_back(2'b00);
    send_req(1'b1, 7'h22, 4'd2);
    wait_done();
    check("rd_queue", exp_wb.size(), 0);
    check("rd_bytes_left", exp_rd.size(), 0);

    // Address NAK on a write: no data requested, STOP, nack flagged.
    rbase = wr_rdy_cycles;
    status_q.push_back(8'h80); status_q.push_back(8'hC0);
    wq.push_back(8'h11);
    exp_hdr(1'b0);
    exp_w(2'd2, 8'h05); exp_r(2'd2);
    exp_done.push_back(2'b10);
    send_req(1'b0, 7'h22, 4'd1);
    wait_done();
    check("nak_queue", exp_wb.size(), 0);
    check("nak_no_wr_ready", wr_rdy_cycles - rbase, 0);
    wq.delete();

    // len=0 write: sixteen bytes then STOP.
    base = wr_hs;
    for (int i = 0; i < 16; i++) wq.push_back(8'(8'h30 + i));
    exp_hdr(1'b0);
    for (int i = 0; i < 16; i++) exp_wbyte(8'(8'h30 + i));
    exp_w(2'd2, 8'h05); exp_r(2'd2);
    exp_done.push_back(2'b00);
    send_req(1'b0, 7'h22, 4'd0);
    wait_done();
    check("wr16_queue", exp_wb.size(), 0);
    check("wr16_handshakes", wr_hs - base, 16);

    // len=0 write with arbitration lost on byte 2: straight to done, no STOP.
    base = wr_hs;
    for (int i = 0; i < 16; i++) wq.push_back(8'(8'h50 + i));
    status_q.push_back(8'h80); status_q.push_back(8'h80);
    status_q.push_back(8'h80); status_q.push_back(8'hA0);
    exp_hdr(1'b0);
    exp_wbyte(8'h50); exp_wbyte(8'h51);
    exp_done.push_back(2'b01);
    send_req(1'b0, 7'h22, 4'd0);
    wait_done();
    check("al_queue", exp_wb.size(), 0);
    check("al_handshakes", wr_hs - base, 2);
    wq.delete();

    // Reset while a Wishbone cycle is held open.
    stall = 1;
    send_req(1'b0, 7'h22, 4'd1);
    n = 0;
    while (!cyc_o && n < 50) begin @(negedge clk_i); n++; end
    repeat (3) @(negedge clk_i);
    #2 check("cyc_held", {29'd0, cyc_o, stb_o, we_o}, 32'd7);
    #1 rst_i = 1;
    #1 check("reset_async", all_outs(), 32'd0);
    exp_wb.delete(); status_q.delete(); wq.delete(); exp_done.delete();
    exp_init();
    stall = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    wait_ready();
    check("reinit_queue", exp_wb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/i2cmb_wb_sequencer.md
I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WB_ADDR_WIDTH, 2, Wishbone address width.
- WB_DATA_WIDTH, 8, Wishbone data width.
- BUS_ID, 0, I2C bus index written during init.
REQ-002 Ports (name direction width meaning), one per line:
- clk_i in 1 clock.
- rst_i in 1 reset, asynchronous, active-high.
- req_valid_i in 1 transfer request valid.
- req_ready_o out 1 sequencer can accept a request.
- req_rw_i in 1 0=write, 1=read.
- req_addr_i in 7 I2C slave address.
- req_len_i in 4 byte count; 0 means 16.
- wr_data_i in 8 write byte.
- wr_data_valid_i in 1 write byte valid.
- wr_data_ready_o out 1 write byte accepted.
- rd_data_o out 8 read byte.
- rd_data_valid_o out 1 read byte strobe.
- done_o out 1 transfer complete pulse.
- nack_o out 1 slave NAK flag, qualified by done_o.
- err_o out 1 arbitration-lost/error flag, qualified by done_o.
- cyc_o, stb_o, we_o out 1 each Wishbone master controls.
- adr_o out WB_ADDR_WIDTH register select: 0=CSR, 1=DPR, 2=CMDR.
- dat_o out WB_DATA_WIDTH write data.
- ack_i in 1 Wishbone acknowledge.
- dat_i in WB_DATA_WIDTH read data.
- irq_i in 1 core interrupt.

Function
REQ-003 Wishbone cycle: cyc_o/stb_o/adr_o/we_o/dat_o asserted the cycle after the state is entered and held stable until ack_i is sampled high; cyc_o/stb_o drop the next cycle; at least one idle cycle separates cycles.
REQ-004 WAIT_IRQ step: idle until irq_i=1, then a read of CMDR; status decode dat_i[7]=DON, [6]=NAK, [5]=AL, [4]=ERR.
REQ-005 Command codes written to CMDR: START 0x04, STOP 0x05, WRITE 0x01, READ_ACK 0x02, READ_NAK 0x03, SET_BUS 0x06.
REQ-006 After reset, INIT runs automatically:
- write CSR=0xC0;
- write DPR=BUS_ID;
- write CMDR=0x06;
- WAIT_IRQ;
- then IDLE.
REQ-007 req_ready_o=1 only in IDLE. A request is accepted when req_valid_i and req_ready_o are both 1; rw, addr and len are latched in that cycle.
REQ-008 Address phase: CMDR=START, WAIT_IRQ, DPR={addr,rw}, CMDR=WRITE, WAIT_IRQ.
REQ-009 NAK on the address phase: skip the data phase, go to STOP, and set nack_o with done_o.
REQ-010 Write data phase, per byte:
- assert wr_data_ready_o until wr_data_valid_i; the byte transfers in the cycle both are 1 (single-cycle handshake);
- DPR=byte, CMDR=WRITE, WAIT_IRQ;
- NAK aborts to STOP with nack_o=1; remaining bytes are not requested.
REQ-011 Read data phase, per byte:
- CMDR=READ_ACK, or READ_NAK for the last byte; WAIT_IRQ; read DPR;
- rd_data_o=dat_i with rd_data_valid_o=1 for exactly one cycle after that DPR ack.
REQ-012 Byte counter: 5-bit, loaded with len (0 loads 16), decremented per completed byte; last byte when counter=1.
REQ-013 STOP: CMDR=STOP, WAIT_IRQ, then done_o=1 for one cycle and return to IDLE. nack_o/err_o are valid only while done_o=1 and are 0 otherwise.
REQ-014 AL or ERR status at any WAIT_IRQ: abort directly to done_o with err_o=1, no STOP issued.
REQ-015 FSM states: INIT_CSR, INIT_DPR, INIT_CMD, INIT_WAIT, IDLE, START, START_WAIT, ADDR_DPR, ADDR_CMD, ADDR_WAIT, WR_GET, WR_DPR, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT, RD_DPR, STOP_CMD, STOP_WAIT, DONE.
REQ-016 req_valid_i while busy is ignored (not latched). irq_i is sampled only in WAIT_IRQ states.

Reset
REQ-017 While rst_i=1, all outputs are 0 and the FSM is in INIT_CSR. Reset mid-transfer abandons any Wishbone cycle immediately (cyc_o=0) and re-runs INIT after deassertion.

Verification
REQ-018 Reset release -> Wishbone writes CSR=0xC0, DPR=BUS_ID, CMDR=0x06, one CMDR read after irq; then req_ready_o=1.
REQ-019 Write request, addr=0x22, len=3, bytes 0xDE,0xAD,0xBE, all ACK -> DPR sequence 0x44,0xDE,0xAD,0xBE; CMDR 0x04,0x01×4,0x05; done_o=1, nack_o=0.
REQ-020 Read request, addr=0x22, len=2, slave returns 0x0A,0x0B -> CMDR 0x02 then 0x03; rd_data_valid_o pulses with 0x0A then 0x0B; done_o=1.
REQ-021 Address NAK (CMDR status 0xC0) -> no wr_data_ready_o; CMDR=0x05 issued; done_o=1 with nack_o=1.
REQ-022 len=0 write -> 16 wr_data handshakes before STOP; AL status (0xA0) mid-transfer -> done_o=1, err_o=1, no STOP.
REQ-023 rst_i asserted during a held Wishbone cycle -> cyc_o=0 asynchronously; INIT repeats after release.
